rs232rx_fifo: RTL

//  Receiver for the 8N1 link driven by the existing rs232tx transmitter: buffered, error-checking.

---
 rtl/rs232rx_fifo.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rs232rx_fifo.sv
// 8N1 serial receiver with mid-bit sampling, glitch rejection, framing/overrun flags
// and a show-ahead FIFO with a valid/rd pop handshake.
module rs232rx_fifo #(
    parameter int CLK_PER_BIT = 1250,
    parameter int FIFO_AW     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW    = $clog2(CLK_PER_BIT);
    localparam int PW    = FIFO_AW + 1;
    localparam int DEPTH = 2 ** FIFO_AW;

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          rx_meta;
    logic          rx_s;
    logic          rx_d;
    logic [1:0]    primed;
    logic          armed;
    logic          start_edge;

    state_t        state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [2:0]    idx_r, idx_n;
    logic [7:0]    shift_r, shift_n;
    logic          push_r, push_n;
    logic          ferr_evt;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovf_evt;

    // Synchroniser and start-edge history. After reset the line must be seen high
    // once (with the flushed synchroniser primed) before a falling edge counts, so a
    // frame already in progress at reset release is not mistaken for a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
            primed  <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
            primed  <= {primed[0], 1'b1};
            armed   <= armed | (primed[1] & rx_s);
        end
    end

    assign start_edge = armed & rx_d & ~rx_s;

    // Receiver FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            push_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            idx_r   <= idx_n;
            shift_r <= shift_n;
            push_r  <= push_n;
        end
    end

    // Receiver FSM next-state: half-bit wait for the start check, then whole bits.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        idx_n    = idx_r;
        shift_n  = shift_r;
        push_n   = 1'b0;
        ferr_evt = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_edge) begin
                    state_n = START;
                    cnt_n   = CNT_ZERO;
                end else begin
                    cnt_n   = CNT_ZERO;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        cnt_n   = CNT_ZERO;
                        idx_n   = 3'd0;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    shift_n = {rx_s, shift_r[7:1]};
                    cnt_n   = CNT_ZERO;
                    if (idx_r == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx_r + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    state_n = IDLE;
                    if (rx_s) begin
                        push_n = 1'b1;
                    end else begin
                        ferr_evt = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = CNT_ZERO;
            end
        endcase
    end

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign do_pop  = rd & valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_r & (~full | do_pop);
    assign ovf_evt = push_r & full & ~do_pop;
    assign data    = valid ? mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= shift_r;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky error flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_evt) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (ovf_evt) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
